branch_predict_unit: RTL and testbench

Parametrised successor to the decode-stage branch calculator: resolves RISC-V jumps and branches and predicts them at fetch through a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It reports registered mispredict redirects and counts branches and mispredicts. It sits between IF (prediction lookup) and ID (resolution and table update).

---
 rtl/branch_predict_unit.sv | 130 +++++++++++++
 tb/tb_branch_predict_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB predictor with ID-stage branch resolution: 0-cycle lookup, 1-cycle registered redirect.
// No backpressure: one resolution per cycle is accepted unconditionally.
module branch_predict_unit #(
    parameter  int ARCH_WIDTH  = 32,
    parameter  int BTB_ENTRIES = 16,
    localparam int IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ARCH_WIDTH-1:0] if_pc,
    output logic                  pred_taken,
    output logic [ARCH_WIDTH-1:0] pred_target,
    input  logic                  btb_flush,
    input  logic                  resolve_valid,
    input  logic [ARCH_WIDTH-1:0] id_pc,
    input  logic [ARCH_WIDTH-1:0] rs1_data,
    input  logic [ARCH_WIDTH-1:0] rs2_data,
    input  logic [ARCH_WIDTH-1:0] imm,
    input  logic [3:0]            branch_type,
    input  logic                  id_pred_taken,
    input  logic [ARCH_WIDTH-1:0] id_pred_target,
    output logic                  redirect_valid,
    output logic [ARCH_WIDTH-1:0] redirect_pc,
    output logic                  resolved_taken,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);
    localparam int TAG_W = ARCH_WIDTH - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] valid;
    logic [TAG_W-1:0]       tag    [BTB_ENTRIES];
    logic [ARCH_WIDTH-1:0]  target [BTB_ENTRIES];
    logic                   uncond [BTB_ENTRIES];
    logic [1:0]             ctr    [BTB_ENTRIES];

    logic [IDX_W-1:0]      lk_idx, up_idx;
    logic [TAG_W-1:0]      lk_tag, up_tag;
    logic                  lk_hit, up_hit;
    logic                  is_br, is_uncond, act_taken, do_res, mispredict;
    logic [ARCH_WIDTH-1:0] act_target, next_pc;
    logic                  unused_pc_lsb;

    assign unused_pc_lsb = ^if_pc[1:0];

    assign lk_idx      = if_pc[IDX_W+1:2];
    assign lk_tag      = if_pc[ARCH_WIDTH-1:IDX_W+2];
    assign lk_hit      = valid[lk_idx] && (tag[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && (uncond[lk_idx] || ctr[lk_idx][1]);
    assign pred_target = pred_taken ? target[lk_idx] : '0;

    always_comb begin
        is_br      = 1'b1;
        is_uncond  = 1'b0;
        act_taken  = 1'b0;
        act_target = id_pc + imm;
        case (branch_type)
            4'd1: begin act_taken = 1'b1; is_uncond = 1'b1; end
            4'd2: begin
                act_taken  = 1'b1;
                is_uncond  = 1'b1;
                act_target = (rs1_data + imm) & ~ARCH_WIDTH'(1);
            end
            4'd3: act_taken = (rs1_data == rs2_data);
            4'd4: act_taken = (rs1_data != rs2_data);
            4'd5: act_taken = ($signed(rs1_data) <  $signed(rs2_data));
            4'd6: act_taken = ($signed(rs1_data) >= $signed(rs2_data));
            4'd7: act_taken = (rs1_data <  rs2_data);
            4'd8: act_taken = (rs1_data >= rs2_data);
            default: is_br = 1'b0;
        endcase
    end

    assign do_res     = resolve_valid && is_br;
    assign mispredict = do_res && ((act_taken != id_pred_taken) ||
                                   (act_taken && (act_target != id_pred_target)));
    assign next_pc    = act_taken ? act_target : id_pc + ARCH_WIDTH'(4);

    assign up_idx = id_pc[IDX_W+1:2];
    assign up_tag = id_pc[ARCH_WIDTH-1:IDX_W+2];
    assign up_hit = valid[up_idx] && (tag[up_idx] == up_tag);

    // Flush takes priority over a same-cycle update; counters survive flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag[i]    <= '0;
                target[i] <= '0;
                uncond[i] <= 1'b0;
                ctr[i]    <= 2'd1;
            end
        end else if (btb_flush) begin
            valid <= '0;
        end else if (do_res) begin
            if (up_hit) begin
                if (act_taken) begin
                    if (ctr[up_idx] != 2'd3) ctr[up_idx] <= ctr[up_idx] + 2'd1;
                    target[up_idx] <= act_target;
                end else if (ctr[up_idx] != 2'd0) begin
                    ctr[up_idx] <= ctr[up_idx] - 2'd1;
                end
                uncond[up_idx] <= is_uncond;
            end else if (act_taken) begin
                valid[up_idx]  <= 1'b1;
                tag[up_idx]    <= up_tag;
                target[up_idx] <= act_target;
                uncond[up_idx] <= is_uncond;
                ctr[up_idx]    <= 2'd2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            resolved_taken   <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            redirect_valid <= mispredict;
            if (mispredict) begin
                redirect_pc    <= next_pc;
                resolved_taken <= act_taken;
            end
            if (do_res)     branch_count     <= branch_count + 32'd1;
            if (mispredict) mispredict_count <= mispredict_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit; redirects are checked by a queue-based monitor.
module tb_branch_predict_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        btb_flush = 1'b0;
    logic        resolve_valid = 1'b0;
    logic [31:0] id_pc = '0, rs1_data = '0, rs2_data = '0, imm = '0;
    logic [3:0]  branch_type = '0;
    logic        id_pred_taken = 1'b0;
    logic [31:0] id_pred_target = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        resolved_taken;
    logic [31:0] branch_count, mispredict_count;

    branch_predict_unit #(.ARCH_WIDTH(32), .BTB_ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .btb_flush(btb_flush),
        .resolve_valid(resolve_valid), .id_pc(id_pc), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .imm(imm), .branch_type(branch_type),
        .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .resolved_taken(resolved_taken), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int unsigned cyc;
        logic [31:0] pc;
        logic        tk;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_bc = 0, exp_mc = 0;
    logic        flush_next = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every observed redirect must match the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (redirect_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_redirect", redirect_pc, 32'hxxxxxxxx);
                end else begin
                    e = q.pop_front();
                    chk("redirect_cycle", cyc, e.cyc);
                    chk("redirect_pc", redirect_pc, e.pc);
                    chk("resolved_taken", {31'd0, resolved_taken}, {31'd0, e.tk});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic res(input logic rv, input logic [3:0] bt, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                       input logic ptk, input logic [31:0] ptg,
                       input logic exp_mp, input logic exp_tk, input logic [31:0] exp_npc);
        exp_t e;
        @(negedge clk);
        resolve_valid = rv; branch_type = bt; id_pc = pc;
        rs1_data = r1; rs2_data = r2; imm = im;
        id_pred_taken = ptk; id_pred_target = ptg;
        btb_flush = flush_next;
        if (exp_mp) begin
            e.cyc = cyc + 1; e.pc = exp_npc; e.tk = exp_tk;
            q.push_back(e);
            exp_mc++;
        end
        if (rv && bt >= 4'd1 && bt <= 4'd8) exp_bc++;
        @(posedge clk);
        #2;
        resolve_valid = 1'b0;
        btb_flush = 1'b0;
        flush_next = 1'b0;
        chk("branch_count", branch_count, exp_bc);
        chk("mispredict_count", mispredict_count, exp_mc);
    endtask

    task automatic look(input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_tgt);
        @(negedge clk);
        if_pc = pc;
        #1;
        chk($sformatf("pred_taken@%h", pc), {31'd0, pred_taken}, {31'd0, exp_tk});
        chk($sformatf("pred_target@%h", pc), pred_target, exp_tgt);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_resolved_taken", {31'd0, resolved_taken}, 32'd0);
        chk("rst_branch_count", branch_count, 32'd0);
        chk("rst_mispredict_count", mispredict_count, 32'd0);
        look(32'h100, 1'b0, 32'h0);

        // Cold beq taken.
        res(1, 4'd3, 32'h100, 32'd5, 32'd5, 32'h20, 0, 32'h0, 1, 1, 32'h120);
        look(32'h100, 1'b1, 32'h120);

        // bne at 0x200 (same index as 0x100): saturation both ways.
        res(1, 4'd4, 32'h200, 32'd1, 32'd2, 32'h40, 1, 32'h240, 0, 1, 32'h240); // ctr 2
        look(32'h100, 1'b0, 32'h0);
        look(32'h200, 1'b1, 32'h240);
        res(1, 4'd4, 32'h200, 32'd1, 32'd2, 32'h40, 1, 32'h240, 0, 1, 32'h240); // 3
        res(1, 4'd4, 32'h200, 32'd1, 32'd2, 32'h40, 1, 32'h240, 0, 1, 32'h240); // 3
        look(32'h200, 1'b1, 32'h240);
        res(1, 4'd4, 32'h200, 32'd3, 32'd3, 32'h40, 0, 32'h0, 0, 0, 32'h204);   // 2
        look(32'h200, 1'b1, 32'h240);
        res(1, 4'd4, 32'h200, 32'd3, 32'd3, 32'h40, 0, 32'h0, 0, 0, 32'h204);   // 1
        look(32'h200, 1'b0, 32'h0);
        res(1, 4'd4, 32'h200, 32'd3, 32'd3, 32'h40, 0, 32'h0, 0, 0, 32'h204);   // 0
        res(1, 4'd4, 32'h200, 32'd3, 32'd3, 32'h40, 0, 32'h0, 0, 0, 32'h204);   // 0
        res(1, 4'd4, 32'h200, 32'd1, 32'd2, 32'h40, 1, 32'h240, 0, 1, 32'h240); // 1
        look(32'h200, 1'b0, 32'h0);
        res(1, 4'd4, 32'h200, 32'd1, 32'd2, 32'h40, 1, 32'h240, 0, 1, 32'h240); // 2
        look(32'h200, 1'b1, 32'h240);

        // Drive ctr to 0, then jalr hits: uncond forces taken at ctr=1.
        res(1, 4'd4, 32'h200, 32'd3, 32'd3, 32'h40, 0, 32'h0, 0, 0, 32'h204);
        res(1, 4'd4, 32'h200, 32'd3, 32'd3, 32'h40, 0, 32'h0, 0, 0, 32'h204);
        res(1, 4'd2, 32'h200, 32'h1003, 32'd0, 32'd4, 1, 32'h1000, 1, 1, 32'h1006);
        look(32'h200, 1'b1, 32'h1006);
        // Cold jalr on its own entry.
        res(1, 4'd2, 32'h304, 32'h1003, 32'd0, 32'd4, 1, 32'h1000, 1, 1, 32'h1006);
        look(32'h304, 1'b1, 32'h1006);

        // Aliasing on index 0.
        res(1, 4'd1, 32'h100, 32'd0, 32'd0, 32'h40, 0, 32'h0, 1, 1, 32'h140);
        look(32'h100, 1'b1, 32'h140);
        look(32'h200, 1'b0, 32'h0);
        res(1, 4'd3, 32'h500, 32'd7, 32'd7, 32'h10, 0, 32'h0, 1, 1, 32'h510);
        look(32'h100, 1'b0, 32'h0);
        look(32'h500, 1'b1, 32'h510);
        res(1, 4'd1, 32'h104, 32'd0, 32'd0, 32'h8, 1, 32'h10c, 0, 1, 32'h10c);
        look(32'h104, 1'b1, 32'h10c);

        // Flush with a simultaneous mispredicting resolve: update dropped, redirect kept.
        flush_next = 1'b1;
        res(1, 4'd1, 32'h108, 32'd0, 32'd0, 32'h4, 0, 32'h0, 1, 1, 32'h10c);
        look(32'h500, 1'b0, 32'h0);
        look(32'h104, 1'b0, 32'h0);
        look(32'h108, 1'b0, 32'h0);
        look(32'h304, 1'b0, 32'h0);

        // Signed vs unsigned comparisons.
        res(1, 4'd5, 32'h400, 32'hffffffff, 32'd1, 32'h80, 1, 32'h480, 0, 1, 32'h480);
        look(32'h400, 1'b1, 32'h480);
        res(1, 4'd7, 32'h404, 32'hffffffff, 32'd1, 32'h80, 0, 32'h0, 0, 0, 32'h408);
        look(32'h404, 1'b0, 32'h0);
        res(1, 4'd8, 32'h408, 32'hffffffff, 32'd1, 32'h10, 0, 32'h0, 1, 1, 32'h418);
        res(1, 4'd6, 32'h40c, 32'hffffffff, 32'd1, 32'h10, 1, 32'h41c, 1, 0, 32'h410);

        // Non-branch types and invalid resolves do nothing.
        res(1, 4'd0, 32'h600, 32'd0, 32'd0, 32'h4, 1, 32'h604, 0, 0, 32'h0);
        res(1, 4'd9, 32'h600, 32'd0, 32'd0, 32'h4, 1, 32'h604, 0, 0, 32'h0);
        res(0, 4'd1, 32'h600, 32'd0, 32'd0, 32'h4, 0, 32'h0, 0, 0, 32'h0);
        look(32'h600, 1'b0, 32'h0);

        // Target-only mispredict.
        res(1, 4'd1, 32'h500, 32'd0, 32'd0, 32'h20, 1, 32'h524, 1, 1, 32'h520);

        // Reset during the cycle a mispredict is being registered.
        @(negedge clk);
        resolve_valid = 1'b1; branch_type = 4'd1; id_pc = 32'h700; imm = 32'h4;
        id_pred_taken = 1'b0; id_pred_target = 32'h0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("midrst_redirect_pc", redirect_pc, 32'd0);
        chk("midrst_resolved_taken", {31'd0, resolved_taken}, 32'd0);
        chk("midrst_branch_count", branch_count, 32'd0);
        chk("midrst_mispredict_count", mispredict_count, 32'd0);
        @(negedge clk);
        resolve_valid = 1'b0;
        rst = 1'b0;
        exp_bc = 0; exp_mc = 0;
        look(32'h400, 1'b0, 32'h0);
        look(32'h500, 1'b0, 32'h0);
        look(32'h700, 1'b0, 32'h0);
        res(1, 4'd3, 32'h800, 32'd1, 32'd1, 32'h8, 0, 32'h0, 1, 1, 32'h808);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
